// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle HI/LO multiply/divide unit beside the EX stage.
// Latency: MULT/DIV family writes HI/LO WIDTH+1 edges after accept, Done the cycle after;
//          MTHI/MTLO write at the accept edge; MFHI/MFLO return data combinationally.
// Backpressure: Stall is raised combinationally for any HI/LO-class request while Busy;
//          EX must hold and re-present the request until Stall drops.
//
// Ports:
//   CLK, RST        clock (rising edge), asynchronous active-low reset
//   Start, Funct    request valid and R-format funct field
//   Rdata1, Rdata2  rs / rt operands
//   Stall, Busy     interlock back to the pipeline, sequencer not idle
//   Done            one-cycle pulse after a MULT/DIV result lands in HI/LO
//   MoveData        HI (MFHI) or LO (MFLO) on an accepted move-from, else 0
//   HI, LO          architectural HI/LO registers
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] Rdata1,
  input  logic [WIDTH-1:0] Rdata2,
  output logic             Stall,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] MoveData,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Funct decode
  logic f_mfhi, f_mthi, f_mflo, f_mtlo, f_mul, f_div, f_signed, f_muldiv, f_class;
  assign f_mfhi   = (Funct == 6'h10);
  assign f_mthi   = (Funct == 6'h11);
  assign f_mflo   = (Funct == 6'h12);
  assign f_mtlo   = (Funct == 6'h13);
  assign f_mul    = (Funct == 6'h18) || (Funct == 6'h19);
  assign f_div    = (Funct == 6'h1A) || (Funct == 6'h1B);
  assign f_signed = (Funct == 6'h18) || (Funct == 6'h1A);
  assign f_muldiv = f_mul || f_div;
  assign f_class  = f_muldiv || f_mfhi || f_mthi || f_mflo || f_mtlo;

  // State registers
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi;   // product high half / partial remainder
  logic [WIDTH-1:0] acc_lo;   // multiplier being shifted out / dividend-to-quotient
  logic [WIDTH-1:0] opb;      // multiplicand or divisor magnitude
  logic             is_div;
  logic             neg_res;  // negate product or quotient in FIX
  logic             neg_rem;  // negate remainder in FIX
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;

  // Operand magnitudes for the signed forms
  logic             a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg  = f_signed && Rdata1[WIDTH-1];
  assign b_neg  = f_signed && Rdata2[WIDTH-1];
  assign b_zero = (Rdata2 == '0);
  assign a_mag  = a_neg ? (-Rdata1) : Rdata1;
  assign b_mag  = b_neg ? (-Rdata2) : Rdata2;

  // Multiply step: conditional add of the multiplicand into the high half,
  // then shift the whole {carry, high, low} accumulator right by one.
  logic [WIDTH:0]   mul_sum, mul_add;
  logic [WIDTH-1:0] mul_hi_nxt, mul_lo_nxt;
  assign mul_sum    = {1'b0, acc_hi} + {1'b0, opb};
  assign mul_add    = acc_lo[0] ? mul_sum : {1'b0, acc_hi};
  assign mul_hi_nxt = mul_add[WIDTH:1];
  assign mul_lo_nxt = {mul_add[0], acc_lo[WIDTH-1:1]};

  // Restoring divide step: shift the next dividend bit into the remainder and
  // subtract the divisor if it fits. The remainder is always below the divisor,
  // so the difference fits back into WIDTH bits.
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_sub, div_hi_nxt, div_lo_nxt;
  assign rem_sh     = {acc_hi, acc_lo[WIDTH-1]};
  assign rem_ge     = (rem_sh >= {1'b0, opb});
  assign rem_sub    = rem_sh[WIDTH-1:0] - opb;
  assign div_hi_nxt = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
  assign div_lo_nxt = {acc_lo[WIDTH-2:0], rem_ge};

  // Sign correction applied on the way into HI/LO
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix, fix_hi, fix_lo;
  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_res ? (-prod) : prod;
  assign q_fix    = neg_res ? (-acc_lo) : acc_lo;
  assign r_fix    = neg_rem ? (-acc_hi) : acc_hi;
  assign fix_hi   = is_div ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign fix_lo   = is_div ? q_fix : prod_fix[WIDTH-1:0];

  // FSM state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM next state and combinational outputs
  always_comb begin
    state_nxt = state;
    Busy      = (state != IDLE);
    Stall     = 1'b0;
    MoveData  = '0;
    case (state)
      IDLE: begin
        if (Start && f_muldiv) state_nxt = CALC;
        if (Start && f_mfhi)   MoveData  = hi_q;
        if (Start && f_mflo)   MoveData  = lo_q;
      end
      CALC: begin
        Stall = Start && f_class;
        if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
      end
      FIX: begin
        Stall     = Start && f_class;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and HI/LO
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt     <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      opb     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state == FIX);
      case (state)
        IDLE: begin
          if (Start && f_muldiv) begin
            cnt     <= '0;
            acc_hi  <= '0;
            acc_lo  <= f_mul ? b_mag : a_mag;
            opb     <= f_mul ? a_mag : b_mag;
            is_div  <= f_div;
            // Divide by zero leaves the all-ones quotient unnegated; the
            // remainder path then reproduces the raw dividend.
            neg_res <= (a_neg ^ b_neg) && !(f_div && b_zero);
            neg_rem <= f_div && a_neg;
          end else if (Start && f_mthi) begin
            hi_q <= Rdata1;
          end else if (Start && f_mtlo) begin
            lo_q <= Rdata1;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            acc_hi <= div_hi_nxt;
            acc_lo <= div_lo_nxt;
          end else begin
            acc_hi <= mul_hi_nxt;
            acc_lo <= mul_lo_nxt;
          end
        end
        FIX: begin
          hi_q <= fix_hi;
          lo_q <= fix_lo;
        end
        default: ;
      endcase
    end
  end

  assign HI   = hi_q;
  assign LO   = lo_q;
  assign Done = done_q;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for the HI/LO multiply/divide resource beside the EX stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO requests from EX.
- Runs 32-iteration shift-add multiply and restoring divide on one shared datapath, and owns the HI/LO registers.
- Drives a stall back to the pipeline while busy, so later HI/LO accesses interlock.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-low reset.
- Start  input  1  EX presents a valid HI/LO-class instruction this cycle.
- Funct  input  6  R-format funct field (MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B).
- Rdata1  input  WIDTH  rs operand (dividend / multiplicand / MTHI/MTLO source).
- Rdata2  input  WIDTH  rt operand (divisor / multiplier).
- Stall  output  1  combinational; request must be held and re-presented.
- Busy  output  1  state != IDLE.
- Done  output  1  one-cycle pulse after HI/LO written by MULT/DIV family.
- MoveData  output  WIDTH  combinational HI (MFHI) or LO (MFLO) when accepted, else 0.
- HI  output  WIDTH  HI register.
- LO  output  WIDTH  LO register.

Behaviour:
- Reset (RST low, any time including mid-operation):
  - state=IDLE; HI, LO, counter, operand regs = 0; Done=0.
  - Operation in flight is discarded.
- States: IDLE, CALC, FIX.
- IDLE, Start=1, funct in MULT/MULTU/DIV/DIVU:
  - Latch |operands| (signed ops) or raw operands (unsigned).
  - Latch result-sign and remainder-sign flags; counter=0; go to CALC.
  - Stall=0 in the accepting cycle.
- IDLE, Start=1, MTHI/MTLO: write HI/LO from Rdata1 at that edge; stay IDLE; Done not pulsed.
- IDLE, Start=1, MFHI/MFLO: MoveData = current HI/LO in the same cycle; no state change.
- IDLE, unrecognised funct: ignored; no stall.
- CALC:
  - One iteration per cycle.
  - Multiply: 2*WIDTH-bit product accumulator, conditional add then shift right.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
  - After counter reaches WIDTH-1 (WIDTH cycles), go to FIX.
- FIX:
  - Apply sign correction (two's complement negate of product, quotient, remainder per flags).
  - Write HI/LO at this edge; go to IDLE.
  - Done=1 in the following cycle only.
- Latency: accept edge T0; HI/LO valid after edge T0+WIDTH+1 (33 for WIDTH=32); Done high during cycle T0+WIDTH+1..T0+WIDTH+2.
- While Busy: any Start=1 with a HI/LO-class funct gives Stall=1. The request is not accepted, MoveData=0, and HI/LO are unaffected. Stall is 0 whenever Start=0.
- In the FIX→IDLE cycle (Busy still 1) requests stall; they are accepted in the next IDLE cycle and see the new HI/LO.
- Arithmetic:
  - MULT signed 64-bit product, MULTU unsigned; HI=upper WIDTH bits, LO=lower.
  - DIV: signed, quotient truncates toward zero, remainder takes dividend's sign.
  - DIVU: unsigned.
- Boundary cases:
  - Divide by zero: LO=all ones, HI=dividend (raw Rdata1); still full latency.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - MULT 0x80000000*0x80000000: HI=0x40000000, LO=0.
- Operands are sampled only at the accept edge; later Rdata changes have no effect.

Test Plan:
- Reset: drive RST low mid-CALC after starting MULTU 5*7 → HI=LO=0, Busy=0, Done never pulses; a fresh MULTU 5*7 afterwards gives LO=35, HI=0 at edge T0+33.
- MULT 0xFFFFFFFE(-2) * 3 → HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU same operands → HI=0x2, LO=0xFFFFFFFA. Done exactly one cycle each.
- DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 → LO=14, HI=2. Divide by zero, DIVU 9/0 → LO=0xFFFFFFFF, HI=9.
- Interlock: start DIV, then hold Start with MFLO from the next cycle → Stall=1 for 33 cycles (all Busy cycles). MFLO accepted the first IDLE cycle with the new quotient on MoveData.
- MTHI 0x12345678 then MFHI next cycle → MoveData=0x12345678, no stall. MTLO issued while Busy → Stall=1, LO unchanged.
- Overflow corners: DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0. MULT 0x80000000*0x80000000 → HI=0x40000000, LO=0.
